// File: rtl/nn_pkg.sv
// Shared types and helpers for the NN datapath blocks: the systolic controller state
// encoding and the default array drain latency.
package nn_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} sys_ctrl_state_t;

  function automatic int sys_lat(input int arow, input int acol, input int bcol);
    return arow + acol + bcol;
  endfunction

endpackage

// File: rtl/systolic_array.sv
// Output-stationary AROWxBCOL MAC grid. A single valid pulse starts one skewed injection of
// the (held) operands; products land in the 2N-bit accumulators AROW+BROW+BCOL-1 cycles later.
module systolic_array #(
  parameter int N    = 16,
  parameter int AROW = 3,
  parameter int BROW = 3,
  parameter int BCOL = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid,
  input  logic [AROW-1:0][BROW-1:0][N-1:0]    a,
  input  logic [BROW-1:0][BCOL-1:0][N-1:0]    b,
  output logic [AROW-1:0][BCOL-1:0][2*N-1:0]  sys_array
);

  localparam int STEPS = AROW + BROW + BCOL;
  localparam int SW    = $clog2(STEPS + 1);

  logic [SW-1:0]                       step_q;
  logic                                run_q;
  logic [SW-1:0]                       step_c;
  logic                                run_c;
  logic [AROW-1:0][N-1:0]              a_edge;
  logic [BCOL-1:0][N-1:0]              b_edge;
  logic [AROW-1:0][BCOL-1:0][N-1:0]    a_pipe;
  logic [AROW-1:0][BCOL-1:0][N-1:0]    b_pipe;
  logic [AROW-1:0][BCOL-1:0][2*N-1:0]  acc;

  // The valid cycle itself is injection step 0.
  assign step_c = valid ? '0 : step_q;
  assign run_c  = valid | run_q;

  // Row i starts i cycles late and column j starts j cycles late, so a[i][k] and b[k][j]
  // meet in PE(i,j); outside the window zeros are injected.
  always_comb begin
    a_edge = '0;
    b_edge = '0;
    for (int i = 0; i < AROW; i++)
      for (int k = 0; k < BROW; k++)
        if (run_c && int'(step_c) == i + k) a_edge[i] = a[i][k];
    for (int j = 0; j < BCOL; j++)
      for (int k = 0; k < BROW; k++)
        if (run_c && int'(step_c) == j + k) b_edge[j] = b[k][j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= '0;
      run_q  <= 1'b0;
      a_pipe <= '0;
      b_pipe <= '0;
      acc    <= '0;
    end else begin
      if (run_c) begin
        step_q <= step_c + SW'(1);
        run_q  <= (int'(step_c) != STEPS - 1);
      end
      for (int i = 0; i < AROW; i++) begin
        a_pipe[i][0] <= a_edge[i];
        for (int j = 1; j < BCOL; j++) a_pipe[i][j] <= a_pipe[i][j-1];
      end
      for (int j = 0; j < BCOL; j++) begin
        b_pipe[0][j] <= b_edge[j];
        for (int i = 1; i < AROW; i++) b_pipe[i][j] <= b_pipe[i-1][j];
      end
      for (int i = 0; i < AROW; i++)
        for (int j = 0; j < BCOL; j++)
          acc[i][j] <= acc[i][j] + (2*N)'(a_pipe[i][j]) * (2*N)'(b_pipe[i][j]);
    end
  end

  assign sys_array = acc;

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for systolic_array: accept operands, clear, launch, drain LAT cycles, hold C
// until consumed. Optional SYSTOLIC_CTRL_PERF_EN adds perf_jobs/perf_stall counters.
module systolic_ctrl
  import nn_pkg::*;
#(
  parameter int N    = 16,
  parameter int AROW = 3,
  parameter int ACOL = 3,
  parameter int BCOL = 3,
  parameter int LAT  = sys_lat(AROW, ACOL, BCOL)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [AROW-1:0][ACOL-1:0][N-1:0]    a,
  input  logic [ACOL-1:0][BCOL-1:0][N-1:0]    b,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [AROW-1:0][BCOL-1:0][2*N-1:0]  c,
  output logic                                busy
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]                         perf_jobs,
  output logic [31:0]                         perf_stall
`endif
);

  localparam int CW = $clog2(LAT + 1);

  sys_ctrl_state_t                     state;
  logic [CW-1:0]                       cnt;
  logic [AROW-1:0][ACOL-1:0][N-1:0]    hold_a;
  logic [ACOL-1:0][BCOL-1:0][N-1:0]    hold_b;
  logic [AROW-1:0][BCOL-1:0][2*N-1:0]  sys_array;
  logic                                arr_rst;
  logic                                arr_valid;
  logic                                in_hs;

  // DONE can hand off to the next job in the same cycle the result is consumed.
  assign in_ready  = !rst && ((state == IDLE) || (state == DONE && out_ready));
  assign in_hs     = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign arr_rst   = rst || (state == CLEAR);
  assign arr_valid = (state == RUN) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_a    <= '0;
      hold_b    <= '0;
      c         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_hs) begin
            hold_a <= a;
            hold_b <= b;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(LAT - 1)) begin
            c         <= sys_array;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_hs) begin
              hold_a <= a;
              hold_b <= b;
              state  <= CLEAR;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_jobs  <= '0;
      perf_stall <= '0;
    end else begin
      if (out_valid && out_ready)  perf_jobs  <= perf_jobs + 32'd1;
      if (out_valid && !out_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

  systolic_array #(
    .N    (N),
    .AROW (AROW),
    .BROW (ACOL),
    .BCOL (BCOL)
  ) u_array (
    .clk       (clk),
    .rst       (arr_rst),
    .valid     (arr_valid),
    .a         (hold_a),
    .b         (hold_b),
    .sys_array (sys_array)
  );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: directed job scenarios plus randomized traffic, checked every
// cycle against a transaction-level model (accept -> result LAT+2 cycles later).
module tb_systolic_ctrl;

  localparam int N    = 16;
  localparam int AROW = 3;
  localparam int ACOL = 3;
  localparam int BCOL = 3;
  localparam int LAT  = AROW + ACOL + BCOL;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [AROW-1:0][ACOL-1:0][N-1:0]   a;
  logic [ACOL-1:0][BCOL-1:0][N-1:0]   b;
  logic [AROW-1:0][BCOL-1:0][2*N-1:0] c;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_jobs, perf_stall;
`endif

  always #5 clk = ~clk;

  systolic_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .busy      (busy)
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    .perf_jobs (perf_jobs),
    .perf_stall(perf_stall)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction model: a job is either absent or 'elapsed' cycles past its acceptance.
  bit          have_job;
  int          elapsed;
  logic [31:0] prod_m [AROW][BCOL];
  logic [31:0] c_m    [AROW][BCOL];
  logic [31:0] jobs_m, stall_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic void calc_prod();
    for (int i = 0; i < AROW; i++)
      for (int j = 0; j < BCOL; j++) begin
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < ACOL; k++) s = s + 32'(a[i][k]) * 32'(b[k][j]);
        prod_m[i][j] = s;
      end
  endfunction

  task automatic step();
    bit ov_exp, ir_exp, hs_in, hs_out;
    @(negedge clk);
    ov_exp = have_job && (elapsed >= LAT + 2);
    ir_exp = !rst && (!have_job || (ov_exp && out_ready));
    chk("in_ready", 32'(in_ready), 32'(ir_exp));
    chk("out_valid", 32'(out_valid), 32'(ov_exp));
    chk("busy", 32'(busy), 32'(have_job));
    for (int i = 0; i < AROW; i++)
      for (int j = 0; j < BCOL; j++)
        chk($sformatf("c[%0d][%0d]", i, j), c[i][j], c_m[i][j]);
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk("perf_jobs", perf_jobs, jobs_m);
    chk("perf_stall", perf_stall, stall_m);
`endif
    hs_in  = ir_exp && in_valid;
    hs_out = ov_exp && out_ready;
    @(posedge clk);
    if (rst) begin
      have_job = 1'b0;
      elapsed  = 0;
      jobs_m   = 32'd0;
      stall_m  = 32'd0;
      for (int i = 0; i < AROW; i++)
        for (int j = 0; j < BCOL; j++) c_m[i][j] = 32'd0;
    end else begin
      if (ov_exp && !out_ready) stall_m = stall_m + 32'd1;
      if (hs_out) begin
        jobs_m   = jobs_m + 32'd1;
        have_job = 1'b0;
      end
      if (hs_in) begin
        have_job = 1'b1;
        elapsed  = 1;
        calc_prod();
      end else if (have_job) begin
        elapsed++;
        if (elapsed == LAT + 2) c_m = prod_m;
      end
    end
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < AROW; i++)
      for (int k = 0; k < ACOL; k++) a[i][k] = N'($urandom);
    for (int k = 0; k < ACOL; k++)
      for (int j = 0; j < BCOL; j++) b[k][j] = N'($urandom);
  endtask

  task automatic ident_a();
    for (int i = 0; i < AROW; i++)
      for (int k = 0; k < ACOL; k++) a[i][k] = (i == k) ? N'(1) : N'(0);
  endtask

  task automatic offer_job();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    have_job = 1'b0; elapsed = 0; jobs_m = 32'd0; stall_m = 32'd0;
    for (int i = 0; i < AROW; i++)
      for (int j = 0; j < BCOL; j++) begin
        c_m[i][j] = 32'd0;
        prod_m[i][j] = 32'd0;
      end
    step(); step();
    rst = 1'b0;

    // Identity times 1..9; operands scrambled right after acceptance.
    ident_a();
    for (int k = 0; k < ACOL; k++)
      for (int j = 0; j < BCOL; j++) b[k][j] = N'(k * BCOL + j + 1);
    offer_job();
    rand_ops();
    repeat (LAT + 4) step();

    // Back-to-back: the next job is offered in the DONE cycle.
    rand_ops();
    offer_job();
    repeat (LAT + 1) step();
    a = {AROW*ACOL{N'(2)}};
    b = {ACOL*BCOL{N'(3)}};
    offer_job();
    repeat (LAT + 4) step();

    // Backpressure: five stalled DONE cycles with a competing offer.
    rand_ops();
    out_ready = 1'b0;
    offer_job();
    repeat (LAT + 1) step();
    rand_ops();
    in_valid = 1'b1;
    repeat (5) step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    // Offers while busy are ignored.
    rand_ops();
    offer_job();
    repeat (3) step();
    rand_ops();
    in_valid = 1'b1;
    repeat (2) step();
    in_valid = 1'b0;
    repeat (LAT) step();

    // Reset mid-RUN, then identity x identity.
    rand_ops();
    offer_job();
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    ident_a();
    for (int k = 0; k < ACOL; k++)
      for (int j = 0; j < BCOL; j++) b[k][j] = (k == j) ? N'(1) : N'(0);
    offer_job();
    repeat (LAT + 4) step();

    // All-ones operands exercise the 2N-bit wrap.
    a = '1;
    b = '1;
    offer_job();
    repeat (LAT + 4) step();

    // Random traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      rand_ops();
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + 4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
